condicionador_botoes: RTL and testbench
=======================================

# condicionador_botoes

Upstream conditioning stage for the seven note buttons of the Sinfonia do Espectro game. It synchronises the raw push-button bus, debounces presses and releases with a single shared filter, and rejects chords. It drives the clean `botoes` bus and a one-cycle press pulse into the game datapath/control. Downstream logic sees at most one stable, one-hot button at a time.

## Interface
Parameters:
- `N_BOTOES`, default 7: width of the button bus.
- `DEBOUNCE_CICLOS`, default 50000: stability window in clock cycles (1 ms at 50 MHz). Must be ≥ 2.

Ports:
- `clock`, in, 1: single system clock, rising-edge.
- `reset`, in, 1: asynchronous, active-high. Clears all state.
- `botoes_brutos`, in, N_BOTOES: raw buttons, active-high, asynchronous to `clock`.
- `botoes`, out, N_BOTOES: debounced one-hot button, or all zeros. Registered.
- `pulso_botao`, out, 1: one-cycle pulse when a valid press is accepted. Registered.
- `multiplo`, out, 1: high while an accepted press was a chord (more than one bit set). Registered.
- `db_estado`, out, 2: current FSM state, for debug.

## Operation
- Every bit of `botoes_brutos` passes through a 2-FF synchronizer, giving `s_sync`.
- One counter of width `$clog2(DEBOUNCE_CICLOS)` and one candidate register (N_BOTOES bits) are shared by all bits.
- FSM states and encodings: OCIOSO=0, FILTRANDO=1, PRESSIONADO=2, SOLTANDO=3.
  - **OCIOSO:**
    - If `s_sync`≠0: candidate←`s_sync`, counter←0, go to FILTRANDO.
  - **FILTRANDO:**
    - If `s_sync`≠candidate: go to OCIOSO. If `s_sync`≠0, the next cycle re-captures it.
    - Else if counter=DEBOUNCE_CICLOS−1: accept the press and go to PRESSIONADO.
      - Candidate one-hot: `botoes`←candidate, `pulso_botao`←1, `multiplo`←0.
      - Candidate not one-hot: `botoes`←0, `pulso_botao` stays 0, `multiplo`←1.
    - Else: counter+1.
  - **PRESSIONADO:**
    - `botoes` and `multiplo` hold.
    - If `s_sync`=0: counter←0, go to SOLTANDO.
    - Changes to `s_sync` while pressed, such as adding a second finger, are ignored.
  - **SOLTANDO:**
    - If `s_sync`≠0: go to PRESSIONADO. This is release bounce; no new pulse is issued.
    - Else if counter=DEBOUNCE_CICLOS−1: `botoes`←0, `multiplo`←0, go to OCIOSO.
    - Else: counter+1.
- `pulso_botao` is high for exactly one cycle per accepted press. Otherwise it is 0.
- Counter saturation cannot occur: the counter is compared before it increments.

## Timing
- **Reset values:**
  - `botoes`=0, `pulso_botao`=0, `multiplo`=0, `db_estado`=0 (OCIOSO).
  - Synchronizers, counter and candidate are cleared.
- **Press latency:** the input must be stable from rising edge t. Then `s_sync` is valid at edge t+2 and FILTRANDO is entered at edge t+3. `botoes` and `pulso_botao` become visible after edge t+3+DEBOUNCE_CICLOS.
- **Release latency:** input low from edge t → `botoes` returns to 0 after edge t+3+DEBOUNCE_CICLOS.
- **Bounce shorter than DEBOUNCE_CICLOS:** produces no output change.
- **Re-press right after release:** a full press latency applies again.
- **Reset asserted mid-operation:** all outputs go to 0 immediately, without waiting for a clock edge. No pulse is issued after reset is released unless a new, full press is seen.
- **Input change on the acceptance cycle:** in FILTRANDO at counter=DEBOUNCE_CICLOS−1, a `s_sync` mismatch takes priority. The press is rejected.

## Structure
- Shared package `sinfonia_pkg`:
  - `typedef enum logic [1:0]` for the states OCIOSO/FILTRANDO/PRESSIONADO/SOLTANDO.
  - Constant `N_NOTAS = 7`.
- Sub-module `sincronizador`: parameterised width, 2-FF synchronizer, asynchronous reset to 0. It is instantiated once for the whole bus.
- The one-hot check is `(x != 0) && ((x & (x-1)) == 0)`, implemented inline.

## Test plan
All scenarios run with DEBOUNCE_CICLOS=4.
1. **Reset:** `reset`=1 at any time → all outputs 0 within the same cycle; `db_estado`=0.
2. **Clean press:** `botoes_brutos`=7'b0000100 held for 20 cycles → `botoes`=7'b0000100 and a single `pulso_botao` exactly 7 edges after the input edge. After release, `botoes`=0 seven edges later.
3. **Press bounce:** input toggles 0/0000100 every 2 cycles for 10 cycles, then held → exactly one `pulso_botao`, 7 edges after the last toggle.
4. **Chord:** 7'b0010010 held → `botoes`=0, `multiplo`=1, no pulse. After release, `multiplo`=0.
5. **Release bounce:** after an accepted press, input drops for 2 cycles then returns → `botoes` stays 0000100 and no second pulse.
6. **Reset mid-FILTRANDO:** reset at counter=2, then release reset with the input still held → exactly one pulse, 7 edges after reset deasserts.

Source files
------------

// File: rtl/sinfonia_pkg.sv
// Shared definitions for the Sinfonia do Espectro button front end.
package sinfonia_pkg;

  // Conditioning FSM states; the encoding is visible on the debug port.
  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  // Number of note buttons on the game panel.
  localparam int N_NOTAS = 7;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for an asynchronous bus; every bit is treated
// independently, so the output is only meaningful once it has settled.
module sincronizador #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] dado_i,
  output logic [LARGURA-1:0] dado_o
);

  logic [LARGURA-1:0] meta_q;
  logic [LARGURA-1:0] sync_q;

  // First stage may go metastable; second stage gives it a cycle to resolve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= dado_i;
      sync_q <= meta_q;
    end
  end

  assign dado_o = sync_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronises the raw button bus, debounces press and
// release with one shared counter, and rejects chords. Downstream sees at
// most one stable one-hot button plus a single-cycle press pulse.
module condicionador_botoes
  import sinfonia_pkg::*;
#(
  parameter int N_BOTOES        = N_NOTAS,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  output logic [N_BOTOES-1:0] botoes,
  output logic                pulso_botao,
  output logic                multiplo,
  output logic [1:0]          db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0]       CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0]       CONT_UM  = CW'(1);
  localparam logic [N_BOTOES-1:0] BUS_UM   = N_BOTOES'(1);

  logic [N_BOTOES-1:0] s_sync;

  estado_t             estado_q, estado_d;
  logic [CW-1:0]       cont_q, cont_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] botoes_q, botoes_d;
  logic                pulso_q, pulso_d;
  logic                mult_q, mult_d;
  logic                cand_um_hot;

  sincronizador #(
    .LARGURA(N_BOTOES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .dado_i(botoes_brutos),
    .dado_o(s_sync)
  );

  // A candidate is a valid note only if exactly one bit is set.
  assign cand_um_hot = (cand_q != '0) && ((cand_q & (cand_q - BUS_UM)) == '0);

  // State, shared counter, candidate and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
      cand_q   <= '0;
      botoes_q <= '0;
      pulso_q  <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      cand_q   <= cand_d;
      botoes_q <= botoes_d;
      pulso_q  <= pulso_d;
      mult_q   <= mult_d;
    end
  end

  // Next-state logic; the counter is compared before incrementing so it
  // never wraps, and an input mismatch always wins over acceptance.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    cand_d   = cand_q;
    botoes_d = botoes_q;
    pulso_d  = 1'b0;
    mult_d   = mult_q;
    unique case (estado_q)
      OCIOSO: begin
        if (s_sync != '0) begin
          cand_d   = s_sync;
          cont_d   = '0;
          estado_d = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s_sync != cand_q) begin
          estado_d = OCIOSO;
        end else if (cont_q == CONT_MAX) begin
          estado_d = PRESSIONADO;
          if (cand_um_hot) begin
            botoes_d = cand_q;
            pulso_d  = 1'b1;
            mult_d   = 1'b0;
          end else begin
            botoes_d = '0;
            mult_d   = 1'b1;
          end
        end else begin
          cont_d = cont_q + CONT_UM;
        end
      end
      PRESSIONADO: begin
        // Extra fingers while held are ignored; only a full release counts.
        if (s_sync == '0) begin
          cont_d   = '0;
          estado_d = SOLTANDO;
        end
      end
      SOLTANDO: begin
        if (s_sync != '0) begin
          estado_d = PRESSIONADO;
        end else if (cont_q == CONT_MAX) begin
          botoes_d = '0;
          mult_d   = 1'b0;
          estado_d = OCIOSO;
        end else begin
          cont_d = cont_q + CONT_UM;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign botoes      = botoes_q;
  assign pulso_botao = pulso_q;
  assign multiplo    = mult_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes with a short debounce window.
// The reference model reasons in terms of run lengths of the synchronised
// input: a press is accepted when a nonzero value has been seen unchanged for
// DEBOUNCE+1 consecutive samples while released, and a release when zero has
// been seen DEBOUNCE+1 consecutive samples while pressed.
module tb_condicionador_botoes;

  localparam int N = 7;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] botoes_brutos = '0;
  logic [N-1:0] botoes;
  logic         pulso_botao;
  logic         multiplo;
  logic [1:0]   db_estado;

  always #5 clock = ~clock;

  condicionador_botoes #(
    .N_BOTOES       (N),
    .DEBOUNCE_CICLOS(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_brutos(botoes_brutos),
    .botoes       (botoes),
    .pulso_botao  (pulso_botao),
    .multiplo     (multiplo),
    .db_estado    (db_estado)
  );

  int checks = 0;
  int failures = 0;
  int pulsos_dut = 0;

  // reference model state
  logic [N-1:0] sh0, sh1, run_val, m_botoes;
  int           run_len;
  bit           m_pressed, m_pulso, m_mult;

  localparam logic [N-1:0] NOTA_A  = 7'b0000100;
  localparam logic [N-1:0] ACORDE  = 7'b0010010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit one_hot(input logic [N-1:0] x);
    return $countones(x) == 1;
  endfunction

  task automatic model_reset();
    sh0 = '0; sh1 = '0; run_val = '0; run_len = 0;
    m_pressed = 1'b0; m_pulso = 1'b0; m_mult = 1'b0; m_botoes = '0;
  endtask

  // One clock edge of the model: the FSM sees the raw value from two edges ago.
  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s;
    s = sh1; sh1 = sh0; sh0 = raw;
    if (s == run_val) run_len++;
    else begin run_val = s; run_len = 1; end
    m_pulso = 1'b0;
    if (!m_pressed && s != '0 && run_len == D + 1) begin
      m_pressed = 1'b1;
      if (one_hot(s)) begin m_botoes = s; m_pulso = 1'b1; m_mult = 1'b0; end
      else begin m_botoes = '0; m_mult = 1'b1; end
    end else if (m_pressed && s == '0 && run_len == D + 1) begin
      m_pressed = 1'b0; m_botoes = '0; m_mult = 1'b0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_edge(botoes_brutos);
    #1;
    if (pulso_botao === 1'b1) pulsos_dut++;
    chk({tag, ".botoes"}, 32'(botoes), 32'(m_botoes));
    chk({tag, ".pulso"}, 32'(pulso_botao), 32'(m_pulso));
    chk({tag, ".multiplo"}, 32'(multiplo), 32'(m_mult));
    chk({tag, ".pressed"}, 32'(db_estado[1]), 32'(m_pressed));
  endtask

  task automatic hold(input logic [N-1:0] v, input int n, input string tag);
    botoes_brutos = v;
    repeat (n) tick(tag);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic apply_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, ".rst_botoes"}, 32'(botoes), 32'd0);
    chk({tag, ".rst_pulso"}, 32'(pulso_botao), 32'd0);
    chk({tag, ".rst_multiplo"}, 32'(multiplo), 32'd0);
    chk({tag, ".rst_estado"}, 32'(db_estado), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] prev, v;
    int k1, k2;
    model_reset();

    // 1: reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("reset.botoes", 32'(botoes), 32'd0);
    chk("reset.pulso", 32'(pulso_botao), 32'd0);
    chk("reset.multiplo", 32'(multiplo), 32'd0);
    chk("reset.estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    hold('0, 3, "idle");
    $display("step reset: checks=%0d", checks);

    // 2: clean press, pulse on the 7th edge, release 7 edges later
    pulsos_dut = 0;
    botoes_brutos = NOTA_A;
    repeat (6) tick("press");
    chk("press.before7", 32'(botoes), 32'd0);
    tick("press");
    chk("press.at7_pulso", 32'(pulso_botao), 32'd1);
    chk("press.at7_botoes", 32'(botoes), 32'(NOTA_A));
    repeat (13) tick("press");
    botoes_brutos = '0;
    repeat (6) tick("release");
    chk("release.before7", 32'(botoes), 32'(NOTA_A));
    tick("release");
    chk("release.at7", 32'(botoes), 32'd0);
    hold('0, 5, "release");
    chk("press.pulses", 32'(pulsos_dut), 32'd1);
    $display("step clean_press: pulses=%0d", pulsos_dut);

    // 3: press bounce, then held
    pulsos_dut = 0;
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? NOTA_A : '0, 2, "bounce");
    repeat (4) tick("bounce");
    chk("bounce.before7", 32'(pulsos_dut), 32'd0);
    tick("bounce");
    chk("bounce.at7_pulso", 32'(pulso_botao), 32'd1);
    hold(NOTA_A, 8, "bounce");
    hold('0, 10, "bounce");
    chk("bounce.pulses", 32'(pulsos_dut), 32'd1);
    $display("step press_bounce: pulses=%0d", pulsos_dut);

    // 4: chord
    pulsos_dut = 0;
    hold(ACORDE, 12, "chord");
    chk("chord.multiplo", 32'(multiplo), 32'd1);
    chk("chord.botoes", 32'(botoes), 32'd0);
    hold('0, 10, "chord");
    chk("chord.multiplo_off", 32'(multiplo), 32'd0);
    chk("chord.pulses", 32'(pulsos_dut), 32'd0);
    $display("step chord: pulses=%0d", pulsos_dut);

    // 5: release bounce keeps the note and issues no second pulse
    hold(NOTA_A, 12, "relbounce");
    pulsos_dut = 0;
    hold('0, 2, "relbounce");
    hold(NOTA_A, 10, "relbounce");
    chk("relbounce.botoes", 32'(botoes), 32'(NOTA_A));
    chk("relbounce.pulses", 32'(pulsos_dut), 32'd0);
    hold('0, 10, "relbounce");
    $display("step release_bounce: pulses=%0d", pulsos_dut);

    // 6: reset while filtering, input still held afterwards
    botoes_brutos = NOTA_A;
    repeat (5) tick("rstfilt");
    chk("rstfilt.filtrando", 32'(db_estado), 32'd1);
    apply_reset("rstfilt");
    pulsos_dut = 0;
    repeat (6) tick("rstfilt");
    chk("rstfilt.before7", 32'(pulsos_dut), 32'd0);
    tick("rstfilt");
    chk("rstfilt.at7_pulso", 32'(pulso_botao), 32'd1);
    hold(NOTA_A, 5, "rstfilt");
    hold('0, 10, "rstfilt");
    chk("rstfilt.pulses", 32'(pulsos_dut), 32'd1);
    $display("step reset_mid_filter: pulses=%0d", pulsos_dut);

    // random segments; distinct nonzero values are always separated by zero
    prev = '0;
    for (int seg = 0; seg < 300; seg++) begin
      case ($urandom_range(0, 3))
        0: v = '0;
        3: begin
          k1 = $urandom_range(0, N - 1);
          k2 = (k1 + $urandom_range(1, N - 1)) % N;
          v = (N'(1) << k1) | (N'(1) << k2);
        end
        default: v = N'(1) << $urandom_range(0, N - 1);
      endcase
      if (prev != '0 && v != '0 && v != prev) hold('0, $urandom_range(1, 3), "rand");
      hold(v, $urandom_range(1, 10), "rand");
      prev = v;
      if ($urandom_range(0, 39) == 0) apply_reset("rand");
    end
    hold('0, 10, "rand");
    $display("step random: checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
